pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the load and flush enables of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB stage registers.
- Inputs are instruction/data memory handshake status, the load-use hazard condition and EX-stage control-flow redirects.
- Contains a small FSM that lets a redirect retire while an instruction fetch is still outstanding, then discards the stale fetch response.

Parameters:
- REG_W, 5, register-index width for rd/rs1/rs2 compares.
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- imem_resp_i  input  1  instruction memory returned data this cycle
- dmem_req_i  input  1  EX_MEM instruction is a load/store (memory access outstanding)
- dmem_resp_i  input  1  data memory completed access this cycle
- ID_EX_mem_read_i  input  1  instruction in EX is a load
- ID_EX_rd_i  input  REG_W  destination of instruction in EX
- IF_ID_rs1_i  input  REG_W  rs1 of instruction in ID
- IF_ID_rs2_i  input  REG_W  rs2 of instruction in ID
- redirect_i  input  1  EX resolved a taken branch/jump (pcmux not pc_plus4)
- pc_load_o  output  1  PC register load enable
- IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o  output  1 each  stage-register load enables
- IF_ID_flush_o  output  1  load a bubble (NOP, ctrl_word '0) into IF_ID
- ID_EX_flush_o  output  1  load a bubble into ID_EX
- squash_o  output  1  high while in DISCARD (for debug/RVFI)

Behaviour:
- FSM states: RUN, DISCARD. Reset/rst → RUN next edge.
- While rst=1: all *_load_o=0; IF_ID_flush_o=1 and ID_EX_flush_o=1; squash_o=0. All outputs combinational from state plus inputs; zero added latency.
- dstall = dmem_req_i & ~dmem_resp_i. istall = ~imem_resp_i.
- lu_haz = ID_EX_mem_read_i & (ID_EX_rd_i != 0) & (ID_EX_rd_i == IF_ID_rs1_i | ID_EX_rd_i == IF_ID_rs2_i).
- Priority in RUN, highest first:
  1. dstall: all loads 0, no flush (full freeze). redirect_i is held by the frozen EX and is acted on once dstall clears.
  2. redirect_i: ID_EX/EX_MEM/MEM_WB_load=1, pc_load=1, IF_ID_load=1 with IF_ID_flush=1, ID_EX_flush=1. If istall, the fetch already in flight targets the wrong path: go to DISCARD. Otherwise stay in RUN.
  3. istall: all loads 0 (freeze).
  4. lu_haz: pc_load=0, IF_ID_load=0, ID_EX_load=1 with ID_EX_flush=1, EX_MEM_load=MEM_WB_load=1. This gives exactly one bubble per hazard; the next cycle has lu_haz=0 because EX holds the bubble.
  5. else: all loads 1, no flush.
- DISCARD:
  - pc_load=0 (PC already holds target), IF_ID_load=1 with IF_ID_flush=1 whenever back stages advance.
  - Back stages follow dstall: all back loads 0 if dstall, else 1 with ID_EX_flush=1.
  - On imem_resp_i, the response is dropped (IF_ID_flush=1) → RUN next cycle, which refetches from target.
  - redirect_i in DISCARD with ~dstall: pc_load=1, flushes as above, remain in DISCARD.
  - rst mid-DISCARD → RUN; outstanding response ignored by the reset rule.
- Simultaneous redirect & lu_haz: redirect wins; the hazard instruction is flushed.
- Simultaneous imem_resp_i & dmem stall in RUN: freeze. The fetched data must be re-presented by the I-side on retry (imem_resp_i held) — an interface requirement on the fetch unit.
- rd=x0 never triggers lu_haz.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles_o, flush_cnt_o, lu_cnt_o (CNT_W each), zeroed on rst. Each cycle they increment, respectively, on any freeze (pc_load=0 & IF_ID_load=0), each accepted redirect, and each lu_haz bubble. All saturate at all-ones.
- Undefined: ports and logic absent; no behaviour change otherwise.

Test Plan:
- rst held 3 cycles, then released with imem_resp_i=1 → all loads 0 and both flushes 1 during reset; cycle after release all loads 1, flushes 0, squash_o=0.
- ID_EX_mem_read_i=1, ID_EX_rd_i=5, IF_ID_rs2_i=5 → one cycle pc_load=0, IF_ID_load=0, ID_EX_flush=1; same with rd=0 → no bubble.
- dmem_req_i=1, dmem_resp_i low for 4 cycles with redirect_i=1 → 4 cycles all loads 0; on 5th cycle (dmem_resp_i=1) pc_load=1, IF_ID_flush=ID_EX_flush=1.
- redirect_i=1 with imem_resp_i=0 → squash_o=1 next cycle. imem_resp_i=1 after 3 cycles → that cycle IF_ID_flush=1 and pc_load=0; next cycle RUN, pc_load=1.
- redirect_i and lu_haz same cycle → redirect behaviour only; with HAZARD_PERF_CNT_EN, flush_cnt_o +1 and lu_cnt_o unchanged.
- With HAZARD_PERF_CNT_EN, imem_resp_i=0 for 10 cycles → stall_cycles_o=10; rst → 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline (optional HAZARD_PERF_CNT_EN counters)
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp_i,
  input  logic             dmem_req_i,
  input  logic             dmem_resp_i,
  input  logic             ID_EX_mem_read_i,
  input  logic [REG_W-1:0] ID_EX_rd_i,
  input  logic [REG_W-1:0] IF_ID_rs1_i,
  input  logic [REG_W-1:0] IF_ID_rs2_i,
  input  logic             redirect_i,
  output logic             pc_load_o,
  output logic             IF_ID_load_o,
  output logic             ID_EX_load_o,
  output logic             EX_MEM_load_o,
  output logic             MEM_WB_load_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_flush_o,
  output logic             squash_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] lu_cnt_o
`endif
);

  typedef enum logic {S_RUN, S_DISCARD} state_t;

  state_t r_state;
  state_t w_next;
  logic   w_dstall;
  logic   w_istall;
  logic   w_lu_haz;
  logic   w_lu_take;

  assign w_dstall = dmem_req_i & ~dmem_resp_i;
  assign w_istall = ~imem_resp_i;
  // x0 is never a real producer, so a load to x0 cannot create a hazard
  assign w_lu_haz = ID_EX_mem_read_i & (ID_EX_rd_i != '0) &
                    ((ID_EX_rd_i == IF_ID_rs1_i) | (ID_EX_rd_i == IF_ID_rs2_i));

  // State register: RUN after reset
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  // Next state and stage enables, decoded from state and live handshakes
  always_comb begin
    w_next        = r_state;
    pc_load_o     = 1'b0;
    IF_ID_load_o  = 1'b0;
    ID_EX_load_o  = 1'b0;
    EX_MEM_load_o = 1'b0;
    MEM_WB_load_o = 1'b0;
    IF_ID_flush_o = 1'b0;
    ID_EX_flush_o = 1'b0;
    squash_o      = 1'b0;
    w_lu_take     = 1'b0;
    if (rst) begin
      IF_ID_flush_o = 1'b1;
      ID_EX_flush_o = 1'b1;
      w_next        = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_dstall) begin
            // full freeze; a pending redirect stays parked in EX
          end else if (redirect_i) begin
            pc_load_o     = 1'b1;
            IF_ID_load_o  = 1'b1;
            ID_EX_load_o  = 1'b1;
            EX_MEM_load_o = 1'b1;
            MEM_WB_load_o = 1'b1;
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
            // a fetch still in flight belongs to the wrong path
            if (w_istall) w_next = S_DISCARD;
          end else if (w_istall) begin
            // freeze until the fetch returns
          end else if (w_lu_haz) begin
            ID_EX_load_o  = 1'b1;
            EX_MEM_load_o = 1'b1;
            MEM_WB_load_o = 1'b1;
            ID_EX_flush_o = 1'b1;
            w_lu_take     = 1'b1;
          end else begin
            pc_load_o     = 1'b1;
            IF_ID_load_o  = 1'b1;
            ID_EX_load_o  = 1'b1;
            EX_MEM_load_o = 1'b1;
            MEM_WB_load_o = 1'b1;
          end
        end
        default: begin
          squash_o = 1'b1;
          if (!w_dstall) begin
            // PC already holds the target unless EX redirects again
            pc_load_o     = redirect_i;
            IF_ID_load_o  = 1'b1;
            ID_EX_load_o  = 1'b1;
            EX_MEM_load_o = 1'b1;
            MEM_WB_load_o = 1'b1;
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
            // stale response dropped this cycle; a held response under a data
            // stall is re-presented by the I-side, so leave only when advancing
            if (!redirect_i && imem_resp_i) w_next = S_RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_lu_cnt;
  logic             w_freeze;
  logic             w_redir_acc;

  assign w_freeze    = ~pc_load_o & ~IF_ID_load_o;
  assign w_redir_acc = redirect_i & ~w_dstall;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if (w_freeze && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redir_acc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_lu_take && (r_lu_cnt != '1))      r_lu_cnt    <= r_lu_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign flush_cnt_o    = r_flush_cnt;
  assign lu_cnt_o       = r_lu_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_resp = 1'b1;
  logic       dmem_req = 1'b0;
  logic       dmem_resp = 1'b0;
  logic       mem_read = 1'b0;
  logic [4:0] ex_rd = '0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       redirect = 1'b0;
  logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic       ifid_flush, idex_flush, squash;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cnt, lu_cnt;
`endif

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_resp_i      (imem_resp),
    .dmem_req_i       (dmem_req),
    .dmem_resp_i      (dmem_resp),
    .ID_EX_mem_read_i (mem_read),
    .ID_EX_rd_i       (ex_rd),
    .IF_ID_rs1_i      (id_rs1),
    .IF_ID_rs2_i      (id_rs2),
    .redirect_i       (redirect),
    .pc_load_o        (pc_load),
    .IF_ID_load_o     (ifid_load),
    .ID_EX_load_o     (idex_load),
    .EX_MEM_load_o    (exmem_load),
    .MEM_WB_load_o    (memwb_load),
    .IF_ID_flush_o    (ifid_flush),
    .ID_EX_flush_o    (idex_flush),
    .squash_o         (squash)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o   (stall_cycles),
    .flush_cnt_o      (flush_cnt),
    .lu_cnt_o         (lu_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [7:0]  outs;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [31:0] lu;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_disc = 1'b0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  logic [31:0] m_lu = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Expected {pc, ifid_l, idex_l, exmem_l, memwb_l, ifid_f, idex_f, squash}
  function automatic logic [7:0] model_out(input bit disc, input bit r, input bit im, input bit dq,
                                           input bit dr, input bit mr, input logic [4:0] rd,
                                           input logic [4:0] s1, input logic [4:0] s2, input bit rdr);
    bit ds  = dq && !dr;
    bit haz = mr && (rd != 5'd0) && (rd == s1 || rd == s2);
    if (r) return 8'h06;
    if (!disc) begin
      if (ds)   return 8'h00;
      if (rdr)  return 8'hFE;
      if (!im)  return 8'h00;
      if (haz)  return 8'h3A;
      return 8'hF8;
    end
    if (ds)  return 8'h01;
    if (rdr) return 8'hFF;
    return 8'h7F;
  endfunction

  task automatic cyc(input string tag, input bit r, input bit im, input bit dq, input bit dr,
                     input bit mr, input logic [4:0] rd, input logic [4:0] s1,
                     input logic [4:0] s2, input bit rdr);
    exp_t e;
    exp_t got;
    logic [7:0] obs;
    bit ds;
    @(posedge clk);
    #1;
    rst = r; imem_resp = im; dmem_req = dq; dmem_resp = dr;
    mem_read = mr; ex_rd = rd; id_rs1 = s1; id_rs2 = s2; redirect = rdr;
    e.tag   = tag;
    e.outs  = model_out(m_disc, r, im, dq, dr, mr, rd, s1, s2, rdr);
    e.stall = m_stall;
    e.flush = m_flush;
    e.lu    = m_lu;
    sb.push_back(e);
    ds = dq && !dr;
    if (r) begin
      m_disc = 1'b0;
      m_stall = '0; m_flush = '0; m_lu = '0;
    end else begin
      if (!e.outs[7] && !e.outs[6] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (!ds && rdr && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
      if (e.outs == 8'h3A && m_lu != 32'hFFFF_FFFF) m_lu = m_lu + 32'd1;
      if (!m_disc) m_disc = !ds && rdr && !im;
      else if (!ds) m_disc = rdr || !im;
    end
    #3;
    obs = {pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush, squash};
    got = sb.pop_front();
    check(got.tag, 64'(obs), 64'(got.outs));
`ifdef HAZARD_PERF_CNT_EN
    check({got.tag, "_stall_cnt"}, 64'(stall_cycles), 64'(got.stall));
    check({got.tag, "_flush_cnt"}, 64'(flush_cnt), 64'(got.flush));
    check({got.tag, "_lu_cnt"}, 64'(lu_cnt), 64'(got.lu));
`endif
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc("reset", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc("after_reset", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // load-use hazard: one bubble, then EX holds the bubble
    cyc("lu_rs2", 0, 1, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
    cyc("lu_after", 0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd5, 0);
    cyc("lu_rs1", 0, 1, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0);
    cyc("lu_x0", 0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    cyc("lu_nomatch", 0, 1, 0, 0, 1, 5'd9, 5'd1, 5'd2, 0);
    // data stall parks a redirect, which fires when the access completes
    for (int i = 0; i < 4; i++) cyc("dstall_redir", 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    cyc("dstall_release", 0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1);
    cyc("run_plain", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // redirect with fetch outstanding -> DISCARD, drop stale response, refetch
    cyc("redir_istall", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    for (int i = 0; i < 3; i++) cyc("discard_wait", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc("discard_drop", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc("refetch", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // DISCARD under data stall, and a second redirect while discarding
    cyc("redir_istall2", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    cyc("discard_dstall", 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc("discard_redir", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    cyc("discard_drop2", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc("refetch2", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // redirect beats load-use hazard
    cyc("redir_vs_lu", 0, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1);
    cyc("after_redir_lu", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // ten-cycle fetch stall, then reset mid-DISCARD
    for (int i = 0; i < 10; i++) cyc("istall", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc("istall_end", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc("redir_istall3", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    cyc("rst_in_discard", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc("after_rst_disc", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // random traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      cyc("random", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0));
    end
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
